// File: rtl/inst_router.sv
// rtl/inst_router.sv - single-entry dispatch router with PRN readiness scoreboard
//
// Purpose:
//    Accepts one renamed instruction per cycle, holds it in a single output
//    register that drives the shared issue-queue bus from flops, and raises
//    inst_valid for the selected FU queue only. A 2^PRN_BITS-bit scoreboard
//    tracks which physical registers hold produced values. It supplies the
//    initial per-source ready bits at load time, and FU writeback broadcasts
//    keep the held ready bits current.
//
// Ports:
//    clk, rst (sync, active low)
//    in_valid/in_ready, in_fu_sel, in_inst_id, in_raw_instr, in_pc
//    in_prn_input_valid/in_prn_input, in_prn_output_valid/in_prn_output
//    flush                       - drop the held instruction
//    inst_valid/queue_ready      - per-FU handshake on the shared bus
//    inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
//    prn_input, prn_output_valid, prn_output - shared bus payload
//    set_prn_ready/set_prn       - FU writeback broadcasts
//    stall_cycles, dispatch_count - statistics
//
// Configuration macro: ROUTER_STATS_EN enables the statistics counters;
// without it both counters are tied to zero.
module inst_router #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   localparam int FU_SEL_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [FU_SEL_BITS-1:0]                           in_fu_sel,
   input  logic [INST_ID_BITS-1:0]                          in_inst_id,
   input  logic [31:0]                                      in_raw_instr,
   input  logic [63:0]                                      in_pc,
   input  logic [MAX_OPERANDS-1:0]                          in_prn_input_valid,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_input,
   input  logic [MAX_OPERANDS-1:0]                          in_prn_output_valid,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            in_prn_output,
   input  logic                                             flush,
   output logic [FU_COUNT-1:0]                              inst_valid,
   input  logic [FU_COUNT-1:0]                              queue_ready,
   output logic [INST_ID_BITS-1:0]                          inst_id,
   output logic [31:0]                                      raw_instr,
   output logic [63:0]                                      instr_pc,
   output logic [MAX_OPERANDS-1:0]                          prn_input_valid,
   output logic [MAX_OPERANDS-1:0]                          prn_input_ready,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_input,
   output logic [MAX_OPERANDS-1:0]                          prn_output_valid,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_output,
   input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready,
   input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
   output logic [31:0]                                      stall_cycles,
   output logic [31:0]                                      dispatch_count
);

   localparam int SB_SIZE = 1 << PRN_BITS;

   logic                                   r_hold_valid;
   logic [FU_SEL_BITS-1:0]                 r_fu_sel;
   logic [INST_ID_BITS-1:0]                r_inst_id;
   logic [31:0]                            r_raw_instr;
   logic [63:0]                            r_pc;
   logic [MAX_OPERANDS-1:0]                r_prn_input_valid;
   logic [MAX_OPERANDS-1:0]                r_prn_input_ready;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  r_prn_input;
   logic [MAX_OPERANDS-1:0]                r_prn_output_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  r_prn_output;
   logic [SB_SIZE-1:0]                     r_sb;

   logic                                   w_transfer;
   logic                                   w_load;
   logic [SB_SIZE-1:0]                     w_bcast_vec;
   logic [SB_SIZE-1:0]                     w_clr_vec;
   logic [MAX_OPERANDS-1:0]                w_src_ready;
   logic [MAX_OPERANDS-1:0]                w_held_ready_next;

   always_comb begin
      inst_valid = '0;
      for (int f = 0; f < FU_COUNT; f++) begin
         inst_valid[f] = r_hold_valid && (r_fu_sel == FU_SEL_BITS'(f));
      end
   end

   assign w_transfer = |(inst_valid & queue_ready);
   // Gated by rst so upstream never sees a handshake while the router is in reset.
   assign in_ready   = rst & (~r_hold_valid | w_transfer) & ~flush;
   assign w_load     = in_valid & in_ready;

   // Decode broadcasts and load-time destination allocations into bit vectors.
   // A clear masks a coincident set, so a freshly allocated PRN stays not-ready.
   always_comb begin
      w_bcast_vec = '0;
      w_clr_vec   = '0;
      for (int f = 0; f < FU_COUNT; f++) begin
         for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (set_prn_ready[f][i]) begin
               w_bcast_vec[set_prn[f][i]] = 1'b1;
            end
         end
      end
      if (w_load) begin
         for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (in_prn_output_valid[i]) begin
               w_clr_vec[in_prn_output[i]] = 1'b1;
            end
         end
      end
   end

   // The registered scoreboard already reflects every older dispatch, so only
   // same-cycle broadcasts need forwarding into the load-time lookup.
   always_comb begin
      w_src_ready       = '0;
      w_held_ready_next = '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
         w_src_ready[i] = ~in_prn_input_valid[i]
                        | r_sb[in_prn_input[i]]
                        | w_bcast_vec[in_prn_input[i]];
         w_held_ready_next[i] = r_prn_input_ready[i] | w_bcast_vec[r_prn_input[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hold_valid       <= 1'b0;
         r_fu_sel           <= '0;
         r_inst_id          <= '0;
         r_raw_instr        <= '0;
         r_pc               <= '0;
         r_prn_input_valid  <= '0;
         r_prn_input_ready  <= '0;
         r_prn_input        <= '0;
         r_prn_output_valid <= '0;
         r_prn_output       <= '0;
         r_sb               <= '1;
      end else begin
         r_sb <= (r_sb | w_bcast_vec) & ~w_clr_vec;
         if (w_load) begin
            r_hold_valid       <= 1'b1;
            r_fu_sel           <= in_fu_sel;
            r_inst_id          <= in_inst_id;
            r_raw_instr        <= in_raw_instr;
            r_pc               <= in_pc;
            r_prn_input_valid  <= in_prn_input_valid;
            r_prn_input_ready  <= w_src_ready;
            r_prn_input        <= in_prn_input;
            r_prn_output_valid <= in_prn_output_valid;
            r_prn_output       <= in_prn_output;
         end else begin
            if (flush || w_transfer) begin
               r_hold_valid <= 1'b0;
            end
            // Ready bits are sticky: they only ever move from 0 to 1 while held.
            if (r_hold_valid) begin
               r_prn_input_ready <= w_held_ready_next;
            end
         end
      end
   end

   assign inst_id          = r_inst_id;
   assign raw_instr        = r_raw_instr;
   assign instr_pc         = r_pc;
   assign prn_input_valid  = r_prn_input_valid;
   assign prn_input_ready  = r_prn_input_ready;
   assign prn_input        = r_prn_input;
   assign prn_output_valid = r_prn_output_valid;
   assign prn_output       = r_prn_output;

`ifdef ROUTER_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_dispatch_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cycles   <= '0;
         r_dispatch_count <= '0;
      end else begin
         if (r_hold_valid && !w_transfer) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_transfer) begin
            r_dispatch_count <= r_dispatch_count + 32'd1;
         end
      end
   end

   assign stall_cycles   = r_stall_cycles;
   assign dispatch_count = r_dispatch_count;
`else
   assign stall_cycles   = '0;
   assign dispatch_count = '0;
`endif

endmodule

// File: tb/tb_inst_router.sv
// tb/tb_inst_router.sv - self-checking bench for inst_router
module tb_inst_router;

   localparam int IB = 6;
   localparam int PB = 6;
   localparam int MO = 3;
   localparam int FC = 4;

`ifdef ROUTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              in_fu_sel;
   logic [IB-1:0]           in_inst_id;
   logic [31:0]             in_raw_instr;
   logic [63:0]             in_pc;
   logic [MO-1:0]           in_prn_input_valid;
   logic [MO-1:0][PB-1:0]   in_prn_input;
   logic [MO-1:0]           in_prn_output_valid;
   logic [MO-1:0][PB-1:0]   in_prn_output;
   logic                    flush;
   logic [FC-1:0]           inst_valid;
   logic [FC-1:0]           queue_ready;
   logic [IB-1:0]           inst_id;
   logic [31:0]             raw_instr;
   logic [63:0]             instr_pc;
   logic [MO-1:0]           prn_input_valid;
   logic [MO-1:0]           prn_input_ready;
   logic [MO-1:0][PB-1:0]   prn_input;
   logic [MO-1:0]           prn_output_valid;
   logic [MO-1:0][PB-1:0]   prn_output;
   logic [FC-1:0][MO-1:0]   set_prn_ready;
   logic [FC-1:0][MO-1:0][PB-1:0] set_prn;
   logic [31:0]             stall_cycles;
   logic [31:0]             dispatch_count;

   inst_router dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_fu_sel(in_fu_sel),
      .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_pc(in_pc),
      .in_prn_input_valid(in_prn_input_valid), .in_prn_input(in_prn_input),
      .in_prn_output_valid(in_prn_output_valid), .in_prn_output(in_prn_output),
      .flush(flush), .inst_valid(inst_valid), .queue_ready(queue_ready),
      .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
      .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
      .prn_input(prn_input), .prn_output_valid(prn_output_valid), .prn_output(prn_output),
      .set_prn_ready(set_prn_ready), .set_prn(set_prn),
      .stall_cycles(stall_cycles), .dispatch_count(dispatch_count)
   );

   typedef struct {
      logic [5:0]  id;
      logic [31:0] raw;
      logic [63:0] pc;
      logic [2:0]  piv;
      logic [2:0]  pir;
      logic [17:0] pin;
      logic [2:0]  pov;
      logic [17:0] pout;
   } exp_t;

   typedef struct {
      bit         v;
      logic [1:0] fu;
      logic [5:0] id;
      logic [2:0] piv;
      logic [5:0] pin0;
      logic [2:0] pov;
      logic [5:0] pout0;
      logic [3:0] qr;
      bit         x_rdy;
      logic [3:0] x_iv;
   } vec_t;

   exp_t        sbq[$];
   vec_t        tbl[8];
   bit          m_hold;
   logic [1:0]  m_fu;
   bit          m_sb[64];
   int unsigned m_stall;
   int unsigned m_disp;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic bit bhit(input logic [5:0] p);
      bit h = 1'b0;
      for (int f = 0; f < FC; f++)
         for (int i = 0; i < MO; i++)
            if (set_prn_ready[f][i] && set_prn[f][i] == p) h = 1'b1;
      return h;
   endfunction

   task automatic drive(input bit v, input logic [1:0] fu, input logic [5:0] id,
                        input logic [2:0] piv, input logic [17:0] pin,
                        input logic [2:0] pov, input logic [17:0] pout,
                        input logic [3:0] qr);
      in_valid            = v;
      in_fu_sel           = fu;
      in_inst_id          = id;
      in_raw_instr        = 32'hA500_0000 | {26'd0, id};
      in_pc               = 64'h8000_0000 + {56'd0, id, 2'b00};
      in_prn_input_valid  = piv;
      in_prn_input        = pin;
      in_prn_output_valid = pov;
      in_prn_output       = pout;
      queue_ready         = qr;
   endtask

   // One clock of reference model: check pre-edge handshake, retire/queue
   // expectations, advance the model, then check registered outputs.
   task automatic tick();
      bit         xfer;
      bit         rdy;
      bit         ld;
      exp_t       e;
      bit         nsb[64];
      logic [3:0] exp_iv;
      #1;
      xfer = m_hold && queue_ready[m_fu];
      rdy  = rst && (!m_hold || xfer) && !flush;
      chk("in_ready", in_ready, rdy);
      ld = in_valid && rdy;
      if (rst) begin
         if (xfer) begin
            e = sbq.pop_front();
            chk("payload",
                {inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
                 prn_input, prn_output_valid, prn_output},
                {e.id, e.raw, e.pc, e.piv, e.pir, e.pin, e.pov, e.pout});
         end else if (flush && m_hold) begin
            void'(sbq.pop_front());
         end
         if (m_hold && !xfer) m_stall++;
         if (xfer) m_disp++;
         nsb = m_sb;
         for (int f = 0; f < FC; f++)
            for (int i = 0; i < MO; i++)
               if (set_prn_ready[f][i]) nsb[set_prn[f][i]] = 1'b1;
         if (m_hold && !xfer && !flush) begin
            for (int k = 0; k < MO; k++)
               if (bhit(sbq[0].pin[k*6 +: 6])) sbq[0].pir[k] = 1'b1;
         end
         if (ld) begin
            e.id   = in_inst_id;
            e.raw  = in_raw_instr;
            e.pc   = in_pc;
            e.piv  = in_prn_input_valid;
            e.pin  = in_prn_input;
            e.pov  = in_prn_output_valid;
            e.pout = in_prn_output;
            for (int k = 0; k < MO; k++)
               e.pir[k] = !in_prn_input_valid[k] || m_sb[in_prn_input[k]] || bhit(in_prn_input[k]);
            sbq.push_back(e);
            for (int k = 0; k < MO; k++)
               if (in_prn_output_valid[k]) nsb[in_prn_output[k]] = 1'b0;
            m_hold = 1'b1;
            m_fu   = in_fu_sel;
         end else if (flush || xfer) begin
            m_hold = 1'b0;
         end
         m_sb = nsb;
      end else begin
         m_hold  = 1'b0;
         m_stall = 0;
         m_disp  = 0;
         sbq.delete();
         foreach (m_sb[p]) m_sb[p] = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_iv = m_hold ? (4'b0001 << m_fu) : 4'b0000;
      chk("inst_valid", inst_valid, exp_iv);
      chk("stall_cycles", stall_cycles, STATS ? m_stall : 32'd0);
      chk("dispatch_count", dispatch_count, STATS ? m_disp : 32'd0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 2'd2, 6'd5,  3'b000, 6'd0,  3'b000, 6'd0, 4'b1111, 1'b1, 4'b0100};
      tbl[1] = '{1'b0, 2'd0, 6'd0,  3'b000, 6'd0,  3'b000, 6'd0, 4'b1111, 1'b1, 4'b0000};
      tbl[2] = '{1'b1, 2'd0, 6'd7,  3'b000, 6'd0,  3'b001, 6'd9, 4'b1111, 1'b1, 4'b0001};
      tbl[3] = '{1'b1, 2'd1, 6'd8,  3'b001, 6'd9,  3'b000, 6'd0, 4'b1111, 1'b1, 4'b0010};
      tbl[4] = '{1'b1, 2'd3, 6'd9,  3'b001, 6'd20, 3'b000, 6'd0, 4'b0111, 1'b1, 4'b1000};
      tbl[5] = '{1'b1, 2'd0, 6'd10, 3'b000, 6'd0,  3'b000, 6'd0, 4'b0111, 1'b0, 4'b1000};
      tbl[6] = '{1'b1, 2'd0, 6'd10, 3'b000, 6'd0,  3'b000, 6'd0, 4'b1111, 1'b1, 4'b0001};
      tbl[7] = '{1'b0, 2'd0, 6'd0,  3'b000, 6'd0,  3'b000, 6'd0, 4'b1111, 1'b1, 4'b0000};

      rst           = 1'b0;
      flush         = 1'b0;
      set_prn_ready = '0;
      set_prn       = '0;
      drive(1'b0, 2'd0, 6'd0, 3'b000, 18'd0, 3'b000, 18'd0, 4'b0000);
      m_hold = 1'b0;
      m_fu   = 2'd0;
      tick();
      tick();
      chk("reset_payload",
          {inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
           prn_input, prn_output_valid, prn_output}, 256'd0);
      rst = 1'b1;

      for (int n = 0; n < 8; n++) begin
         drive(tbl[n].v, tbl[n].fu, tbl[n].id, tbl[n].piv, {12'd0, tbl[n].pin0},
               tbl[n].pov, {12'd0, tbl[n].pout0}, tbl[n].qr);
         #1;
         chk($sformatf("vec%0d_in_ready", n), in_ready, tbl[n].x_rdy);
         tick();
         chk($sformatf("vec%0d_inst_valid", n), inst_valid, tbl[n].x_iv);
      end

      // Producer of PRN 9, then a consumer that must wait; broadcast wakes it while held.
      drive(1'b1, 2'd1, 6'd20, 3'b000, 18'd0, 3'b001, 18'd9, 4'b0000);
      tick();
      drive(1'b1, 2'd2, 6'd21, 3'b001, 18'd9, 3'b000, 18'd0, 4'b0010);
      tick();
      chk("req021_held_id", inst_id, 6'd21);
      chk("req021_not_ready", prn_input_ready, 3'b110);
      drive(1'b0, 2'd0, 6'd0, 3'b000, 18'd0, 3'b000, 18'd0, 4'b0000);
      set_prn_ready[1][0] = 1'b1;
      set_prn[1][0]       = 6'd9;
      tick();
      set_prn_ready = '0;
      set_prn       = '0;
      chk("req021_woken", prn_input_ready, 3'b111);
      chk("req021_still_held", inst_valid, 4'b0100);

      // Back-pressure on FU 3 for five cycles.
      drive(1'b1, 2'd3, 6'd30, 3'b000, 18'd0, 3'b000, 18'd0, 4'b0100);
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 2'd0, 6'd31, 3'b000, 18'd0, 3'b000, 18'd0, 4'b0000);
         tick();
         chk("req022_stable_id", inst_id, 6'd30);
         chk("req022_stable_pc", instr_pc, 64'h8000_0000 + 64'd120);
      end
      drive(1'b0, 2'd0, 6'd0, 3'b000, 18'd0, 3'b000, 18'd0, 4'b1000);
      tick();

      // Allocation of PRN 12 coinciding with a broadcast of PRN 12.
      drive(1'b1, 2'd0, 6'd40, 3'b000, 18'd0, 3'b001, 18'd12, 4'b0000);
      set_prn_ready[0][0] = 1'b1;
      set_prn[0][0]       = 6'd12;
      tick();
      set_prn_ready = '0;
      set_prn       = '0;
      drive(1'b1, 2'd1, 6'd41, 3'b001, 18'd12, 3'b000, 18'd0, 4'b0001);
      tick();
      chk("req023_clear_wins", prn_input_ready, 3'b110);

      // Flush while stalled; the offered load (which would clear PRN 9) must not land.
      drive(1'b1, 2'd2, 6'd50, 3'b000, 18'd0, 3'b001, 18'd9, 4'b0000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b1, 2'd2, 6'd51, 3'b011, {6'd0, 6'd9, 6'd12}, 3'b000, 18'd0, 4'b0000);
      tick();
      chk("req024_sb_kept", prn_input_ready, 3'b110);

      // Mid-stream reset with competing load and broadcast.
      rst = 1'b0;
      drive(1'b1, 2'd0, 6'd52, 3'b000, 18'd0, 3'b001, 18'd3, 4'b1111);
      set_prn_ready[2][1] = 1'b1;
      set_prn[2][1]       = 6'd7;
      tick();
      chk("midrst_payload",
          {inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
           prn_input, prn_output_valid, prn_output}, 256'd0);
      rst           = 1'b1;
      set_prn_ready = '0;
      set_prn       = '0;
      drive(1'b1, 2'd0, 6'd53, 3'b001, 18'd12, 3'b000, 18'd0, 4'b0000);
      tick();
      chk("post_rst_sb_set", prn_input_ready, 3'b111);
      drive(1'b0, 2'd0, 6'd0, 3'b000, 18'd0, 3'b000, 18'd0, 4'b1111);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_router.md
INST_ROUTER -- requirements
Module: inst_router

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INST_ID_BITS, 6, instruction tag width.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, operand slots per instruction.
- FU_COUNT, 4, number of FU issue queues.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-low reset.
- in_valid, in, 1, upstream renamed instruction valid.
- in_ready, out, 1, router accepts the upstream instruction.
- in_fu_sel, in, $clog2(FU_COUNT), target FU index.
- in_inst_id / in_raw_instr / in_pc, in, INST_ID_BITS/32/64, instruction tag, instruction word and PC.
- in_prn_input_valid[MAX_OPERANDS] / in_prn_input[MAX_OPERANDS], in, 1/PRN_BITS, source operands.
- in_prn_output_valid[MAX_OPERANDS] / in_prn_output[MAX_OPERANDS], in, 1/PRN_BITS, destination operands.
- flush, in, 1, discard the held instruction.
- inst_valid[FU_COUNT], out, 1 each, per-queue valid, one-hot or zero.
- queue_ready[FU_COUNT], in, 1 each, per-queue ready.
- inst_id / raw_instr / instr_pc / prn_input_valid / prn_input_ready / prn_input / prn_output_valid / prn_output, out, shared issue-queue bus, widths as the corresponding inputs.
- set_prn_ready[FU_COUNT][MAX_OPERANDS] / set_prn[FU_COUNT][MAX_OPERANDS], in, 1/PRN_BITS, FU writeback broadcasts.
- stall_cycles / dispatch_count, out, 32 each, statistics counters.

Function
REQ-003 The router SHALL hold one output register (hold_valid plus the full payload) that drives the shared bus directly from flops.
REQ-004 inst_valid[f] SHALL be 1 only when hold_valid=1 and the held fu_sel equals f.
REQ-005 A transfer SHALL occur on a cycle where inst_valid[f] and queue_ready[f] are both 1.
REQ-006 in_ready SHALL equal (!hold_valid | transfer) & !flush, so throughput is 1/cycle when the target queue is ready.
REQ-007 On in_valid & in_ready, the register SHALL load the input on the next edge, and hold_valid=1.
REQ-008 On a transfer with no new load, hold_valid SHALL go to 0 on the next edge.
REQ-009 A held payload SHALL NOT change except for its ready bits (REQ-012).
REQ-010 The scoreboard SHALL be 2^PRN_BITS ready bits.
- Bit p is set on the edge after any set_prn_ready[f][i] with set_prn[f][i]=p.
- Bit p is cleared on the edge after a load whose in_prn_output_valid[i]=1 with in_prn_output[i]=p.
- If a set and a clear of the same bit coincide, the clear SHALL win.
REQ-011 At load, each held prn_input_ready[i] SHALL be scoreboard[in_prn_input[i]], OR'd with any same-cycle broadcast matching that source.
- A slot whose prn_input_valid=0 SHALL load ready=1.
REQ-012 While held, each prn_input_ready[i] SHALL become 1 on the edge after a broadcast matching prn_input[i]; it SHALL never return to 0.
REQ-013 Load-time lookup SHALL account for the instruction currently being loaded only, not for older dispatches; the scoreboard state already reflects those.
REQ-014 On flush=1, hold_valid SHALL become 0 on the next edge, with no load and no scoreboard clear that cycle.
- Broadcast sets still apply during flush.
REQ-015 Dispatch latency from input acceptance to inst_valid SHALL be exactly 1 cycle.

Reset
REQ-016 With rst=0 at a clk edge, the router SHALL set: hold_valid=0, all inst_valid=0, all scoreboard bits=1, stall_cycles=0, dispatch_count=0, and all bus payload fields=0.
REQ-017 Reset SHALL override load, transfer, flush and broadcasts in the same cycle.
- in_ready SHALL read 0 while rst=0.

Configuration
REQ-018 With ROUTER_STATS_EN defined:
- stall_cycles SHALL increment on each cycle with hold_valid=1 and no transfer.
- dispatch_count SHALL increment on each transfer.
- Both counters SHALL wrap at 2^32.
REQ-019 Without ROUTER_STATS_EN, both counters SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-020 Reset, then in_valid with fu_sel=2, inst_id=5, queue_ready=all 1 -> inst_valid=4'b0100 one cycle later with inst_id=5; hold_valid=0 the cycle after.
REQ-021 Load an instruction with prn_output=9, then an instruction sourcing PRN 9 -> the second dispatches with prn_input_ready[0]=0; assert set_prn[1][0]=9 with ready -> that ready bit reads 1 on the next cycle, while the instruction is still held.
REQ-022 queue_ready[3]=0 for 5 cycles with an instruction held for FU 3 -> in_ready=0, payload stable, stall_cycles=5 (with ROUTER_STATS_EN); release -> transfer, dispatch_count+1.
REQ-023 Same cycle: a load allocates PRN 12 as output and a broadcast sets PRN 12 -> scoreboard[12]=0 afterwards.
REQ-024 Flush while holding with queue_ready=0 -> hold_valid=0 next cycle, scoreboard unchanged; then assert rst=0 mid-stream -> all outputs reach REQ-016 values after one edge.
